bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock). It sits directly upstream of the per-digit seven-segment decoders. It takes a binary measurement, such as a frequency count, and produces one packed 4-bit BCD nibble per display digit. The output register holds the last result during a conversion so the display never flickers.

Parameters:
WIDTH, 16, bit width of the binary input; must be >= 1.
DIGITS, 5, number of BCD digits produced; must be >= 1.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request a conversion of bin; honoured only when ready=1.
bin  input  WIDTH  unsigned binary value; sampled on the accepting edge only.
ready  output  1  1 = idle, start will be accepted.
done  output  1  single-cycle pulse: bcd/overflow just updated.
bcd  output  4*DIGITS  packed BCD result; bcd[3:0] = least-significant digit, bcd[4*DIGITS-1:4*DIGITS-4] = most-significant digit; each nibble feeds one segment decoder.
overflow  output  1  1 = last converted value exceeded 10^DIGITS-1.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: ready=1, done=0, bcd=0, overflow=0, FSM=IDLE, working registers cleared.
- Reset has priority over all other inputs. Reset asserted mid-conversion aborts it: no done pulse, and bcd/overflow return to 0.
- FSM states: IDLE, SHIFT.
- IDLE:
  - ready=1.
  - On an edge with start=1: load binary shift register <= bin, BCD working register <= 0, overflow working flag <= 0, bit counter <= WIDTH-1; go to SHIFT.
- SHIFT:
  - ready=0.
  - Each edge performs one iteration:
    - Every working digit >= 5 gets +3, each digit independently, in the same cycle.
    - Then {BCD working, binary shift} is shifted left by 1, with the binary MSB entering BCD bit 0.
    - A 1 shifted out of the top BCD digit sets the working overflow flag (sticky for this conversion).
    - The counter decrements.
  - On the edge where the counter is 0 (the WIDTH-th SHIFT edge):
    - Perform the final iteration.
    - Load the bcd output from the post-shift working value; if the working flag is set, load all nibbles = 4'h9 instead (saturate).
    - Load overflow <= working flag.
    - Set done <= 1 and return to IDLE.
- done is 1 for exactly one cycle and is 0 in all other cycles. ready is 1 in that same cycle.
- Latency: start accepted at edge k → done high, with new bcd/overflow, in the cycle after edge k+WIDTH. Throughput is one conversion per WIDTH+1 cycles.
- start while ready=0 is ignored entirely; no queuing.
- start=1 in the done cycle is accepted (back-to-back). Holding start high continuously gives repeated conversions.
- bin changes after the accepting edge have no effect on the conversion in progress.
- bcd and overflow change only on a done edge or on reset; they are stable otherwise.
- Arithmetic: each digit add-3 is 4-bit unsigned; a digit never exceeds 9 after a completed shift for in-range values. Working register width = 4*DIGITS, plus the overflow capture.
- If 2^WIDTH-1 <= 10^DIGITS-1, overflow can never assert. This is legal; no special casing is needed.

Test Plan:
- Reset, then start with bin=0 (WIDTH=16, DIGITS=5) → done in the cycle after edge k+16; bcd=20'h00000, overflow=0; ready=0 for exactly 16 cycles.
- bin=65535 → bcd=20'h65535, overflow=0. Then bin=9 → bcd=20'h00009. bcd holds 20'h65535 throughout the second conversion until its done edge.
- WIDTH=16, DIGITS=3, bin=1234 → overflow=1, bcd=12'h999. Then bin=999 → overflow=0, bcd=12'h999. Then bin=1000 → overflow=1.
- During a conversion of bin=4321, pulse start with bin=7 at cycles k+3 and k+10 → single done with bcd=20'h04321; no second done follows.
- Start bin=500, assert reset at edge k+8 → no done; ready=1, bcd=0, overflow=0 after reset. Next start with bin=42 → bcd=20'h00042.
- Hold start=1 continuously with bin stepping 10, 11, 12 on each accepting edge → done pulses spaced 17 cycles apart; bcd sequence 20'h00010, 20'h00011, 20'h00012.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// The bcd/overflow outputs hold the previous result until a new conversion completes.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready=1, waiting for start; outputs hold last result
// SHIFT | one add-3/shift iteration per edge, WIDTH edges in total
module bin_to_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] bin_sr;
    logic [BW-1:0]   bcd_work;
    logic [BW-1:0]   bcd_adj;
    logic [BW-1:0]   bcd_next;
    logic            ovf_work;
    logic            ovf_next;
    logic [CW-1:0]   cnt;

    // One double-dabble iteration: correct every digit, then shift in the next binary bit.
    always_comb begin
        bcd_adj = bcd_work;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_work[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {bcd_adj[BW-2:0], bin_sr[WIDTH-1]};
        ovf_next = ovf_work | bcd_adj[BW-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            bin_sr   <= '0;
            bcd_work <= '0;
            ovf_work <= 1'b0;
            cnt      <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr   <= bin;
                        bcd_work <= '0;
                        ovf_work <= 1'b0;
                        cnt      <= CW'(WIDTH - 1);
                        ready    <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_sr   <= bin_sr << 1;
                    bcd_work <= bcd_next;
                    ovf_work <= ovf_next;
                    cnt      <= cnt - CW'(1);
                    if (cnt == '0) begin
                        // Saturate to all nines so the display shows an obvious over-range value.
                        bcd      <= ovf_next ? {DIGITS{4'h9}} : bcd_next;
                        overflow <= ovf_next;
                        done     <= 1'b1;
                        ready    <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: a 5-digit and a 3-digit instance share stimulus.
module tb_bin_to_bcd_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        ready5, done5, ovf5;
    logic [19:0] bcd5;
    logic        ready3, done3, ovf3;
    logic [11:0] bcd3;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
        .clock(clock), .reset(reset), .start(start), .bin(bin),
        .ready(ready5), .done(done5), .bcd(bcd5), .overflow(ovf5)
    );

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(3)) dut3 (
        .clock(clock), .reset(reset), .start(start), .bin(bin),
        .ready(ready3), .done(done3), .bcd(bcd3), .overflow(ovf3)
    );

    typedef struct {
        logic [15:0] bin;
        logic [19:0] exp5;
        logic        ovf5;
        logic [11:0] exp3;
        logic        ovf3;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start one conversion and wait for done; reports latency, ready-low cycles and hold violations.
    task automatic run_conv(input logic [15:0] v, input logic [19:0] prev5,
                            output int lat, output int rdy_low, output int hold_bad);
        @(negedge clock);
        start = 1'b1;
        bin   = v;
        @(posedge clock);
        #1;
        start    = 1'b0;
        bin      = 16'($urandom);
        lat      = 0;
        rdy_low  = 0;
        hold_bad = 0;
        while (!done5 && lat < 40) begin
            if (!ready5) rdy_low++;
            if (bcd5 !== prev5) hold_bad++;
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat, rdy_low, hold_bad, ndone, dlat;
        int cyc, n, accept_next;
        int done_at[3];
        logic [19:0] prev5;
        logic [19:0] seq_exp[3];

        vecs[0] = '{16'd0,     20'h00000, 1'b0, 12'h000, 1'b0};
        vecs[1] = '{16'd65535, 20'h65535, 1'b0, 12'h999, 1'b1};
        vecs[2] = '{16'd9,     20'h00009, 1'b0, 12'h009, 1'b0};
        vecs[3] = '{16'd1234,  20'h01234, 1'b0, 12'h999, 1'b1};
        vecs[4] = '{16'd999,   20'h00999, 1'b0, 12'h999, 1'b0};
        vecs[5] = '{16'd1000,  20'h01000, 1'b0, 12'h999, 1'b1};
        vecs[6] = '{16'd7,     20'h00007, 1'b0, 12'h007, 1'b0};
        vecs[7] = '{16'd59999, 20'h59999, 1'b0, 12'h999, 1'b1};

        reset = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_ready5", ready5, 1);
        check("reset_done5", done5, 0);
        check("reset_bcd5", bcd5, 0);
        check("reset_ovf5", ovf5, 0);
        check("reset_ready3", ready3, 1);
        check("reset_bcd3", bcd3, 0);
        @(negedge clock);
        reset = 1'b0;

        prev5 = 20'h0;
        for (int i = 0; i < 8; i++) begin
            run_conv(vecs[i].bin, prev5, lat, rdy_low, hold_bad);
            check($sformatf("v%0d_latency", i), lat, 16);
            check($sformatf("v%0d_ready_low", i), rdy_low, 16);
            check($sformatf("v%0d_hold", i), hold_bad, 0);
            check($sformatf("v%0d_done3", i), done3, 1);
            check($sformatf("v%0d_ready_in_done", i), ready5, 1);
            check($sformatf("v%0d_bcd5", i), bcd5, vecs[i].exp5);
            check($sformatf("v%0d_ovf5", i), ovf5, vecs[i].ovf5);
            check($sformatf("v%0d_bcd3", i), bcd3, vecs[i].exp3);
            check($sformatf("v%0d_ovf3", i), ovf3, vecs[i].ovf3);
            @(posedge clock);
            #1;
            check($sformatf("v%0d_done_pulse", i), done5, 0);
            check($sformatf("v%0d_bcd_stable", i), bcd5, vecs[i].exp5);
            prev5 = vecs[i].exp5;
        end

        // Starts while busy must be ignored.
        @(negedge clock);
        start = 1'b1;
        bin   = 16'd4321;
        @(posedge clock);
        #1;
        start = 1'b0;
        ndone = 0;
        dlat  = 0;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clock);
            start = (e == 3 || e == 10);
            bin   = 16'd7;
            @(posedge clock);
            #1;
            if (done5) begin
                ndone++;
                dlat = e;
            end
            if (dlat == e) check("busy_bcd5", bcd5, 20'h04321);
        end
        start = 1'b0;
        check("busy_done_count", ndone, 1);
        check("busy_done_latency", dlat, 16);
        check("busy_ovf3_set", ovf3, 1);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clock);
        start = 1'b1;
        bin   = 16'd500;
        @(posedge clock);
        #1;
        start = 1'b0;
        ndone = 0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clock);
            #1;
            if (done5) ndone++;
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_ready5", ready5, 1);
        check("abort_bcd5", bcd5, 0);
        check("abort_ovf5", ovf5, 0);
        check("abort_bcd3", bcd3, 0);
        check("abort_ovf3", ovf3, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clock);
            #1;
            if (done5) ndone++;
        end
        check("abort_no_done", ndone, 0);
        run_conv(16'd42, 20'h0, lat, rdy_low, hold_bad);
        check("after_abort_latency", lat, 16);
        check("after_abort_bcd5", bcd5, 20'h00042);
        check("after_abort_hold", hold_bad, 0);

        // Start held high: back-to-back conversions.
        seq_exp[0] = 20'h00010;
        seq_exp[1] = 20'h00011;
        seq_exp[2] = 20'h00012;
        @(negedge clock);
        start = 1'b1;
        bin   = 16'd10;
        @(posedge clock);
        #1;
        bin         = 16'd11;
        cyc         = 0;
        n           = 0;
        accept_next = 0;
        while (n < 3 && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
            if (accept_next != 0) begin
                bin         = 16'(10 + n + 1);
                accept_next = 0;
            end
            if (done5) begin
                done_at[n] = cyc;
                check($sformatf("b2b_bcd5_%0d", n), bcd5, seq_exp[n]);
                n++;
                accept_next = 1;
                if (n == 3) start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_done_count", n, 3);
        if (n == 3) begin
            check("b2b_first_latency", done_at[0], 16);
            check("b2b_spacing_1", done_at[1] - done_at[0], 17);
            check("b2b_spacing_2", done_at[2] - done_at[1], 17);
        end
        repeat (3) @(posedge clock);
        #1;
        check("b2b_idle_after", ready5, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
